// File: rtl/fxp_mul_if.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_mul_if
//  Description : Start/done handshake bundle for the sequential fixed-point
//                multiplier.
//                master : drives a, b, start; receives p, done, busy, overflow
//                slave  : the multiplier itself
//  Revision    : 1.0  initial release
// ============================================================================
interface fxp_mul_if #(
   parameter int WIDTH = 32
) ();
   logic [WIDTH-1:0] a;        // multiplicand, signed fixed-point
   logic [WIDTH-1:0] b;        // multiplier, signed fixed-point
   logic             start;    // request, sampled only while idle
   logic [WIDTH-1:0] p;        // product, held until the next result
   logic             done;     // one-cycle result-valid pulse
   logic             busy;     // operation in progress
   logic             overflow; // result saturated, updated with done

   modport master (
      output a, b, start,
      input  p, done, busy, overflow
   );

   modport slave (
      input  a, b, start,
      output p, done, busy, overflow
   );
endinterface
`default_nettype wire

// File: rtl/fxp_mul.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_mul
//  Description : Sequential signed fixed-point multiplier, Q(WIDTH-FRAC).FRAC.
//                Shift-add on operand magnitudes over WIDTH cycles, then a
//                sign fix-up cycle that truncates toward zero and saturates.
//                Result appears WIDTH+1 cycles after the accepting edge.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - fxp_mul_if.slave (a, b, start / p, done, busy,
//                        overflow)
//  Revision    : 1.0  initial release
// ============================================================================
module fxp_mul #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   fxp_mul_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 1);

   // Largest positive / most negative representable results.
   localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
   // Magnitude limits, widened to the accumulator width for comparison.
   localparam logic [2*WIDTH-1:0] c_pos_lim = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [2*WIDTH-1:0] c_neg_lim = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             r_state;
   logic [2*WIDTH-1:0] r_mcand;   // |a|, shifted left one place per RUN cycle
   logic [WIDTH-1:0]   r_mplier;  // |b|, shifted right one place per RUN cycle
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic               r_sign;
   logic [WIDTH-1:0]   r_p;
   logic               r_done;
   logic               r_busy;
   logic               r_ovf;

   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;
   logic [2*WIDTH-1:0] w_mag;

   // Unsigned negation of the most negative value yields 2^(WIDTH-1), which
   // is exactly the magnitude wanted when read back as unsigned.
   assign w_a_abs = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign w_b_abs = bus.b[WIDTH-1] ? -bus.b : bus.b;

   // Dropping the low FRAC bits of the magnitude rounds toward zero.
   assign w_mag = r_acc >> FRAC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sign   <= 1'b0;
         r_p      <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_a_abs};
                  r_mplier <= w_b_abs;
                  r_sign   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end

            RUN: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + r_mcand;
               end
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= FIX;
               end
            end

            FIX: begin
               if (!r_sign) begin
                  if (w_mag > c_pos_lim) begin
                     r_p   <= c_max_pos;
                     r_ovf <= 1'b1;
                  end else begin
                     r_p   <= w_mag[WIDTH-1:0];
                     r_ovf <= 1'b0;
                  end
               end else begin
                  // Magnitude 2^(WIDTH-1) negates onto itself: the most
                  // negative value, representable without saturation.
                  // A zero magnitude negates to zero, so no negative zero.
                  if (w_mag > c_neg_lim) begin
                     r_p   <= c_min_neg;
                     r_ovf <= 1'b1;
                  end else begin
                     r_p   <= -w_mag[WIDTH-1:0];
                     r_ovf <= 1'b0;
                  end
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.p        = r_p;
   assign bus.done     = r_done;
   assign bus.busy     = r_busy;
   assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/fxp_mul.md
Name: fxp_mul

Overview:
- Sequential signed fixed-point multiplier: the inverse of the team's `div` divider, with the same start/done handshake and number format.
- Used by the fluid-simulation datapath wherever a product is needed and a combinational WIDTH x WIDTH multiplier is too large.
- Shift-add over WIDTH cycles on operand magnitudes, then sign fix-up, truncation to Q(WIDTH-FRAC).FRAC and saturation.

Parameters:
- WIDTH, 32: operand/result width in bits, two's complement.
- FRAC, 16: fractional bits; the default is Q16.16, scale factor 2^-16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  multiplicand, signed fixed-point.
- b  input  WIDTH  multiplier, signed fixed-point.
- start  input  1  request; sampled only in IDLE.
- p  output  WIDTH  product, signed fixed-point; held until the next result.
- done  output  1  one-cycle pulse; p and overflow are valid in that cycle.
- busy  output  1  high while an operation is in progress.
- overflow  output  1  result saturated; updated together with done.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: on assertion, immediately and regardless of state: state=IDLE, p=0, done=0, busy=0, overflow=0, internal accumulator/counter=0.
  - Reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE, RUN, FIX.
  - IDLE, start=1 at edge E0:
    - latch |a| and |b| as WIDTH-bit unsigned (|-2^(WIDTH-1)| = 2^(WIDTH-1), no wrap);
    - latch sign = a[MSB] ^ b[MSB];
    - clear the 2*WIDTH-bit accumulator; counter=0; busy=1; go to RUN.
  - IDLE, start=0: no change.
  - RUN, edges E1..E_WIDTH, one multiplier bit per edge, LSB first:
    - if the current bit is 1, add the shifted multiplicand to the accumulator;
    - increment counter; after the WIDTH-th bit, go to FIX.
  - FIX, edge E_(WIDTH+1):
    - mag = accumulator >> FRAC, which truncates the magnitude, i.e. rounds toward zero;
    - positive result: if mag > 2^(WIDTH-1)-1, p = 2^(WIDTH-1)-1 and overflow=1; else p = mag.
    - negative result: if mag > 2^(WIDTH-1), p = -2^(WIDTH-1) and overflow=1; else p = -mag.
    - If mag == 0, p = 0 regardless of sign (no negative zero issue).
    - done=1, busy=0, go to IDLE.
- Latency: done is high in the cycle after E_(WIDTH+1), i.e. WIDTH+1 cycles after the accepting edge. Default: 33 cycles.
- done is high for exactly one cycle; otherwise 0.
- start while busy=1 is ignored, not queued. Operands may change freely after E0.
- Back-to-back: start high in the same cycle done=1 is accepted (state is IDLE). The new operation does not disturb the p/overflow just presented.
- p and overflow change only at FIX (or reset).
- Accumulator is 2*WIDTH bits; no internal overflow is possible.

Test Plan:
- Reset values: assert rst_n=0 asynchronously between edges → p=0, done=0, busy=0, overflow=0 immediately.
- Basic products, default params:
  - a=0x00028000 (2.5), b=0x00040000 (4.0), start pulse → done exactly 33 cycles after the accepting edge; p=0x000A0000 (10.0), overflow=0.
  - a=0xFFFE8000 (-1.5), b=0x00020000 (2.0) → p=0xFFFD0000 (-3.0).
  - a=0xFFFE8000, b=0xFFFE8000 → p=0x00024000 (2.25).
- Truncation toward zero:
  - a=0x00000001, b=0x00008000 → p=0.
  - a=0xFFFFFFFF, b=0x00008000 → p=0 (not -1 LSB).
  - a=0x00030000, b=0x00005555 → p=0x0000FFFF.
- Saturation:
  - a=0x00C80000 (200.0), b=0x01900000 (400.0) → p=0x7FFFFFFF, overflow=1.
  - a=0xFF380000 (-200.0), same b → p=0x80000000, overflow=1.
  - a=0x80000000, b=0x00010000 (1.0) → p=0x80000000, overflow=0.
- Handshake:
  - start re-pulsed at cycle 10 of an operation → ignored; single done with the original result.
  - start held high → operations back-to-back, one done every 34 cycles.
  - Operand change after E0 → no effect on p.
- Reset mid-operation: rst_n low at cycle 15 of RUN, released, then a new start → no stale done; new result correct, with latency 33.
